spi_rx_master: RTL

SPI_RX_MASTER -- requirements
Module: spi_rx_master

---
 rtl/spi_rx_master_if.sv | 22 ++
 rtl/spi_rx_master.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/spi_rx_master_if.sv
// Signal bundle between the SPI receive master and its consumer/sensor side.
// The master modport is the controller's view; slave is the consumer plus sensor view.
interface spi_rx_master_if;
   logic        spi_ena;
   logic        miso;
   logic        sclk;
   logic        cs_n;
   logic        spi_not_busy;
   logic [31:0] spi_rx_data;
   logic        rx_valid;
   logic        frame_fault;

   modport master (
      input  spi_ena, miso,
      output sclk, cs_n, spi_not_busy, spi_rx_data, rx_valid, frame_fault
   );

   modport slave (
      output spi_ena, miso,
      input  sclk, cs_n, spi_not_busy, spi_rx_data, rx_valid, frame_fault
   );
endinterface

// File: rtl/spi_rx_master.sv
// Mode-0 SPI master that reads one 32-bit MSB-first frame per request.
// Optional open-wire detection is built only when SPI_FAULT_DETECT_EN is defined.
module spi_rx_master #(
   parameter int CLK_DIV  = 4,
   parameter int HOLD_CYC = 4
) (
   input  logic            clk,
   input  logic            rst,
   spi_rx_master_if.master bus
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
   localparam logic [6:0]    LAST_EDGE = 7'd64;

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t      state_q, state_d;
   logic [CW-1:0] half_q, half_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [6:0]  edge_q, edge_d;
   logic        sclk_q, sclk_d;
   logic        cs_n_q, cs_n_d;
   logic [31:0] shift_q, shift_d;
   logic [31:0] rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        frame_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         half_q     <= '0;
         hold_q     <= '0;
         edge_q     <= '0;
         sclk_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         shift_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         half_q     <= half_d;
         hold_q     <= hold_d;
         edge_q     <= edge_d;
         sclk_q     <= sclk_d;
         cs_n_q     <= cs_n_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      half_d     = half_q;
      hold_d     = hold_q;
      edge_d     = edge_q;
      sclk_d     = sclk_q;
      cs_n_d     = cs_n_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      frame_done = 1'b0;

      case (state_q)
         IDLE: begin
            sclk_d = 1'b0;
            cs_n_d = 1'b1;
            half_d = '0;
            if (bus.spi_ena) begin
               state_d = SETUP;
               cs_n_d  = 1'b0;
               edge_d  = '0;
               shift_d = '0;
            end
         end
         SETUP: begin
            // The entry into SHIFT is itself the first rising sclk edge.
            if (half_q == HALF_LAST) begin
               state_d = SHIFT;
               half_d  = '0;
               sclk_d  = 1'b1;
               edge_d  = 7'd1;
               shift_d = {shift_q[30:0], bus.miso};
            end else begin
               half_d = half_q + 1'b1;
            end
         end
         SHIFT: begin
            if (half_q == HALF_LAST) begin
               half_d = '0;
               if (edge_q == LAST_EDGE) begin
                  // sclk has been low a full half-period; release cs_n and publish.
                  state_d    = HOLD;
                  cs_n_d     = 1'b1;
                  hold_d     = '0;
                  rx_data_d  = shift_q;
                  rx_valid_d = 1'b1;
                  frame_done = 1'b1;
               end else begin
                  sclk_d = ~sclk_q;
                  edge_d = edge_q + 7'd1;
                  if (!sclk_q) begin
                     shift_d = {shift_q[30:0], bus.miso};
                  end
               end
            end else begin
               half_d = half_q + 1'b1;
            end
         end
         HOLD: begin
            sclk_d = 1'b0;
            cs_n_d = 1'b1;
            if (hold_q == HOLD_LAST) begin
               hold_d = '0;
               half_d = '0;
               // A still-asserted request chains straight into the next frame.
               if (bus.spi_ena) begin
                  state_d = SETUP;
                  cs_n_d  = 1'b0;
                  edge_d  = '0;
                  shift_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
         end
      endcase
   end

`ifdef SPI_FAULT_DETECT_EN
   logic fault_q, fault_d;

   always_comb begin
      fault_d = fault_q;
      if (frame_done) begin
         fault_d = (shift_q == 32'h0000_0000) || (shift_q == 32'hFFFF_FFFF);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end

   assign bus.frame_fault = fault_q;
`else
   assign bus.frame_fault = 1'b0;
`endif

   assign bus.sclk         = sclk_q;
   assign bus.cs_n         = cs_n_q;
   assign bus.spi_not_busy = (state_q == IDLE);
   assign bus.spi_rx_data  = rx_data_q;
   assign bus.rx_valid     = rx_valid_q;
endmodule
